// File: rtl/key_autorepeat_if.sv
// Bundles the tick/key inputs and the event outputs of key_autorepeat.
//   time_flag     : one-cycle sample tick from the system timebase
//   key_in        : raw, asynchronous, active-low button
//   key_pulse     : press accepted or auto-repeat
//   long_pulse    : hold reached the long-press threshold
//   release_pulse : release accepted
//   key_level     : debounced pressed level (1 = pressed)
// master drives the tick and key; slave is the debouncer itself.
interface key_autorepeat_if;
    logic time_flag;
    logic key_in;
    logic key_pulse;
    logic long_pulse;
    logic release_pulse;
    logic key_level;

    modport master (
        output time_flag,
        output key_in,
        input  key_pulse,
        input  long_pulse,
        input  release_pulse,
        input  key_level
    );

    modport slave (
        input  time_flag,
        input  key_in,
        output key_pulse,
        output long_pulse,
        output release_pulse,
        output key_level
    );
endinterface

// File: rtl/key_autorepeat.sv
// Debounced push-button with long-press detection and optional auto-repeat.
// The raw key is synchronised, then sampled only on time_flag ticks; a press or
// release is accepted after DEBOUNCE_TICKS consecutive stable samples.
//
// Ports:
//   clock : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : key_autorepeat_if.slave (time_flag, key_in in; pulses and level out)
//
// Build option: define KEY_AUTOREPEAT_EN to enable auto-repeat after a long
// press. Without it, a long press emits only long_pulse and the key then stays
// silent until released.
module key_autorepeat #(
    parameter int unsigned DEBOUNCE_TICKS = 3,
    parameter int unsigned LONG_TICKS     = 100,
    parameter int unsigned REPEAT_TICKS   = 20,
    parameter int unsigned CNT_W          = 8
) (
    input logic            clock,
    input logic            reset,
    key_autorepeat_if.slave bus
);

    localparam int unsigned MaxTicks = (32'd1 << CNT_W) - 32'd1;

    // Every threshold must fit the counter so it can never wrap.
    if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > MaxTicks ||
        LONG_TICKS < 1 || LONG_TICKS > MaxTicks ||
        REPEAT_TICKS < 1 || REPEAT_TICKS > MaxTicks) begin : g_bad_params
        $error("key_autorepeat: tick parameters must be in 1..2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] DbTicks   = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] LongTicks = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RepTicks  = CNT_W'(REPEAT_TICKS);
`endif

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StDbPress   = 3'd1,
        StHeld      = 3'd2,
        StDbRelease = 3'd3
`ifdef KEY_AUTOREPEAT_EN
        ,
        StRepeat    = 3'd4
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             key_pulse_q, key_pulse_d;
    logic             long_pulse_q, long_pulse_d;
    logic             release_pulse_q, release_pulse_d;
    logic             key_level_q, key_level_d;
    logic             ks;

    assign ks      = sync2_q;
    assign cnt_inc = cnt_q + CntOne;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // Synchroniser resets to the released level so no false press is seen.
            sync1_q         <= 1'b1;
            sync2_q         <= 1'b1;
            state_q         <= StIdle;
            cnt_q           <= '0;
            key_pulse_q     <= 1'b0;
            long_pulse_q    <= 1'b0;
            release_pulse_q <= 1'b0;
            key_level_q     <= 1'b0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            key_pulse_q     <= key_pulse_d;
            long_pulse_q    <= long_pulse_d;
            release_pulse_q <= release_pulse_d;
            key_level_q     <= key_level_d;
        end
    end

    always_comb begin
        sync1_d         = bus.key_in;
        sync2_d         = sync1_q;
        state_d         = state_q;
        cnt_d           = cnt_q;
        key_level_d     = key_level_q;
        key_pulse_d     = 1'b0;
        long_pulse_d    = 1'b0;
        release_pulse_d = 1'b0;

        if (bus.time_flag) begin
            unique case (state_q)
                StIdle: begin
                    if (!ks) begin
                        // First low sample already counts as one stable tick.
                        if (DbTicks == CntOne) begin
                            state_d     = StHeld;
                            cnt_d       = '0;
                            key_level_d = 1'b1;
                            key_pulse_d = 1'b1;
                        end else begin
                            state_d = StDbPress;
                            cnt_d   = CntOne;
                        end
                    end
                end

                StDbPress: begin
                    if (ks) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_inc == DbTicks) begin
                        state_d     = StHeld;
                        cnt_d       = '0;
                        key_level_d = 1'b1;
                        key_pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end

                StHeld: begin
                    if (ks) begin
                        if (DbTicks == CntOne) begin
                            state_d         = StIdle;
                            cnt_d           = '0;
                            key_level_d     = 1'b0;
                            release_pulse_d = 1'b1;
                        end else begin
                            state_d = StDbRelease;
                            cnt_d   = CntOne;
                        end
                    end else begin
`ifdef KEY_AUTOREPEAT_EN
                        if (cnt_inc == LongTicks) begin
                            state_d      = StRepeat;
                            cnt_d        = '0;
                            long_pulse_d = 1'b1;
                            key_pulse_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
`else
                        // Counter parks at LongTicks so the long event fires once per hold.
                        if (cnt_q != LongTicks) begin
                            cnt_d        = cnt_inc;
                            long_pulse_d = (cnt_inc == LongTicks);
                        end
`endif
                    end
                end

`ifdef KEY_AUTOREPEAT_EN
                StRepeat: begin
                    if (ks) begin
                        if (DbTicks == CntOne) begin
                            state_d         = StIdle;
                            cnt_d           = '0;
                            key_level_d     = 1'b0;
                            release_pulse_d = 1'b1;
                        end else begin
                            state_d = StDbRelease;
                            cnt_d   = CntOne;
                        end
                    end else if (cnt_inc == RepTicks) begin
                        cnt_d       = '0;
                        key_pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
`endif

                StDbRelease: begin
                    if (!ks) begin
                        // Short high blip: resume holding, long-press timing restarts.
                        state_d = StHeld;
                        cnt_d   = '0;
                    end else if (cnt_inc == DbTicks) begin
                        state_d         = StIdle;
                        cnt_d           = '0;
                        key_level_d     = 1'b0;
                        release_pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end

                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus.key_pulse     = key_pulse_q;
    assign bus.long_pulse    = long_pulse_q;
    assign bus.release_pulse = release_pulse_q;
    assign bus.key_level     = key_level_q;

endmodule

// File: tb/tb_key_autorepeat.sv
// Self-checking bench for key_autorepeat: directed scenarios with literal
// tick-position expectations, then randomized ticks/key/reset, all compared
// every cycle against a sample-run based model of the debouncer.
module tb_key_autorepeat;

    localparam int DB   = 3;
    localparam int LONG = 100;
    localparam int REP  = 20;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   tick_idx = 0;
    int   clk_cnt = 0;
    bit   rand_ticks = 1'b0;
    bit   started = 1'b0;
    int   kp_q[$];
    int   lp_q[$];
    int   rp_q[$];

    key_autorepeat_if bus ();

    key_autorepeat #(
        .DEBOUNCE_TICKS(DB),
        .LONG_TICKS    (LONG),
        .REPEAT_TICKS  (REP),
        .CNT_W         (8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // Tracks run lengths of identical key samples and hold time since the
    // last (re)start of a hold; events follow directly from those counts.
    logic s1, s2;
    int   run_lo, run_hi, hold_n, rep_n;
    bit   level, long_done;
    logic e_kp, e_lp, e_rp;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 = 1'b1; s2 = 1'b1;
            run_lo = 0; run_hi = 0; hold_n = 0; rep_n = 0;
            level = 1'b0; long_done = 1'b0;
            e_kp = 1'b0; e_lp = 1'b0; e_rp = 1'b0;
        end else begin
            logic ks;
            bit   after_hi;
            ks = s2;           // key as seen two clocks ago
            s2 = s1;
            s1 = bus.key_in;
            e_kp = 1'b0; e_lp = 1'b0; e_rp = 1'b0;
            if (bus.time_flag) begin
                if (!ks) begin
                    after_hi = (run_hi != 0);
                    run_lo++;
                    run_hi = 0;
                    if (!level) begin
                        if (run_lo == DB) begin
                            level = 1'b1; e_kp = 1'b1;
                            hold_n = 0; long_done = 1'b0; rep_n = 0;
                        end
                    end else if (after_hi) begin
                        hold_n = 0; long_done = 1'b0; rep_n = 0;
                    end else if (!long_done) begin
                        hold_n++;
                        if (hold_n == LONG) begin
                            e_lp = 1'b1; long_done = 1'b1; rep_n = 0;
`ifdef KEY_AUTOREPEAT_EN
                            e_kp = 1'b1;
`endif
                        end
                    end else begin
`ifdef KEY_AUTOREPEAT_EN
                        rep_n++;
                        if (rep_n == REP) begin
                            e_kp = 1'b1; rep_n = 0;
                        end
`endif
                    end
                end else begin
                    run_hi++;
                    run_lo = 0;
                    if (level && run_hi == DB) begin
                        level = 1'b0; e_rp = 1'b1;
                    end
                end
            end
        end
    end

    always @(posedge clock) if (bus.time_flag) tick_idx++;

    // ---------------- checking ----------------
    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model plus pulse-position recording.
    always @(negedge clock) begin
        if (started) begin
            check_bit("key_pulse", bus.key_pulse, e_kp);
            check_bit("long_pulse", bus.long_pulse, e_lp);
            check_bit("release_pulse", bus.release_pulse, e_rp);
            check_bit("key_level", bus.key_level, level);
            if (bus.key_pulse) kp_q.push_back(tick_idx);
            if (bus.long_pulse) lp_q.push_back(tick_idx);
            if (bus.release_pulse) rp_q.push_back(tick_idx);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.time_flag = 1'b0;
        forever begin
            @(negedge clock);
            clk_cnt++;
            if (rand_ticks) bus.time_flag = ($urandom_range(0, 2) == 0);
            else            bus.time_flag = (clk_cnt % 10 == 0);
        end
    end

    // Returns shortly after the next tick edge.
    task automatic wait_tick();
        int n = 0;
        forever begin
            @(posedge clock);
            if (bus.time_flag) break;
            n++;
            if (n > 100) begin
                check_int("tick_timeout", n, 0);
                break;
            end
        end
        @(negedge clock);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic clear_q();
        kp_q.delete(); lp_q.delete(); rp_q.delete();
    endtask

    initial begin
        #1_500_000;
        check_int("watchdog", 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int t0;
        int td;
        int exp_kp[5];
        exp_kp[0] = 0; exp_kp[1] = 100; exp_kp[2] = 120; exp_kp[3] = 140; exp_kp[4] = 160;
        bus.key_in = 1'b1;
        repeat (3) @(negedge clock);
        started = 1'b1;
        #1;
        check_bit("reset_key_level", bus.key_level, 1'b0);
        check_bit("reset_key_pulse", bus.key_pulse, 1'b0);
        reset = 1'b0;
        wait_ticks(4);

        // Basic press and release.
        clear_q();
        bus.key_in = 1'b0;
        t0 = tick_idx;
        wait_ticks(3);
        #10;
        check_int("press_count", kp_q.size(), 1);
        if (kp_q.size() > 0) check_int("press_tick", kp_q[0], t0 + 3);
        check_bit("press_level", bus.key_level, 1'b1);
        bus.key_in = 1'b1;
        t0 = tick_idx;
        wait_ticks(3);
        #10;
        check_int("release_count", rp_q.size(), 1);
        if (rp_q.size() > 0) check_int("release_tick", rp_q[0], t0 + 3);
        check_bit("release_level", bus.key_level, 1'b0);
        check_int("release_no_extra_press", kp_q.size(), 1);

        // Two-tick glitch is ignored.
        clear_q();
        bus.key_in = 1'b0;
        wait_ticks(2);
        bus.key_in = 1'b1;
        wait_ticks(5);
        check_int("glitch_press", kp_q.size(), 0);
        check_int("glitch_release", rp_q.size(), 0);
        check_bit("glitch_level", bus.key_level, 1'b0);

        // Long hold of 163 ticks.
        clear_q();
        bus.key_in = 1'b0;
        t0 = tick_idx;
        wait_ticks(163);
        bus.key_in = 1'b1;
        wait_ticks(5);
`ifdef KEY_AUTOREPEAT_EN
        check_int("hold_key_count", kp_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < kp_q.size()) check_int("hold_key_tick", kp_q[i], t0 + 3 + exp_kp[i]);
`else
        check_int("hold_key_count", kp_q.size(), 1);
        if (kp_q.size() > 0) check_int("hold_key_tick", kp_q[0], t0 + 3);
`endif
        check_int("hold_long_count", lp_q.size(), 1);
        if (lp_q.size() > 0) check_int("hold_long_tick", lp_q[0], t0 + 103);
        check_int("hold_release_count", rp_q.size(), 1);

        // One-tick high blip at hold tick 50 restarts long timing.
        clear_q();
        bus.key_in = 1'b0;
        t0 = tick_idx;
        wait_ticks(53);
        bus.key_in = 1'b1;
        wait_tick();
        bus.key_in = 1'b0;
        wait_ticks(110);
        check_int("blip_release", rp_q.size(), 0);
        check_int("blip_long_count", lp_q.size(), 1);
        if (lp_q.size() > 0) check_int("blip_long_tick", lp_q[0], t0 + 155);
`ifdef KEY_AUTOREPEAT_EN
        check_int("blip_key_count", kp_q.size(), 2);
`else
        check_int("blip_key_count", kp_q.size(), 1);
`endif
        bus.key_in = 1'b1;
        wait_ticks(5);

        // Reset in the middle of a hold.
        clear_q();
        bus.key_in = 1'b0;
        wait_ticks(43);
        check_bit("pre_reset_level", bus.key_level, 1'b1);
        reset = 1'b1;
        #1;
        check_bit("rst_key_pulse", bus.key_pulse, 1'b0);
        check_bit("rst_long_pulse", bus.long_pulse, 1'b0);
        check_bit("rst_release_pulse", bus.release_pulse, 1'b0);
        check_bit("rst_key_level", bus.key_level, 1'b0);
        repeat (3) @(negedge clock);
        clear_q();
        reset = 1'b0;
        td = tick_idx;
        wait_ticks(5);
        check_int("rst_release_count", rp_q.size(), 0);
        check_int("rst_repress_count", kp_q.size(), 1);
        if (kp_q.size() > 0) check_int("rst_repress_tick", kp_q[0], td + 3);
        bus.key_in = 1'b1;
        wait_ticks(5);

        // Randomized ticks, key activity and occasional resets.
        rand_ticks = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int dur;
            if ($urandom_range(0, 7) == 0) dur = $urandom_range(200, 1000);
            else                           dur = $urandom_range(1, 40);
            bus.key_in = $urandom_range(0, 1);
            repeat (dur) @(negedge clock);
            if ($urandom_range(0, 49) == 0) begin
                #2;
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clock);
                #2;
                reset = 1'b0;
            end
        end
        rand_ticks = 1'b0;
        repeat (20) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_autorepeat.md
KEY_AUTOREPEAT -- requirements
Module: key_autorepeat

Interface
REQ-001 SHALL have parameter DEBOUNCE_TICKS, default 3: consecutive stable ticks required to accept a press or a release.
REQ-002 SHALL have parameter LONG_TICKS, default 100: held ticks, counted after press acceptance, before the long-press event.
REQ-003 SHALL have parameter REPEAT_TICKS, default 20: held ticks between auto-repeat pulses.
REQ-004 SHALL have parameter CNT_W, default 8: tick counter width; all tick parameters SHALL be in 1..2^CNT_W-1.
REQ-005 SHALL have port clock  input  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port time_flag  input  1  one-cycle sample tick (10 ms in the clock top); ignored when low.
REQ-008 SHALL have port key_in  input  1  raw button, asynchronous, active-low (0 = pressed).
REQ-009 SHALL have port key_pulse  output  1  one-cycle pulse on accepted press and on each auto-repeat.
REQ-010 SHALL have port long_pulse  output  1  one-cycle pulse when a hold reaches LONG_TICKS.
REQ-011 SHALL have port release_pulse  output  1  one-cycle pulse on accepted release.
REQ-012 SHALL have port key_level  output  1  debounced pressed level (1 = pressed).

Function
REQ-013 SHALL pass key_in through a 2-flop synchronizer; only the synchronized value (ks) is used; ks low means pressed.
REQ-014 SHALL update state and counter only in cycles where time_flag=1; in all other cycles state and counter hold.
REQ-015 SHALL implement states IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE.
REQ-016 IDLE, tick with ks=0: go to DB_PRESS, cnt=1; tick with ks=1: stay.
REQ-017 DB_PRESS, tick with ks=1: go to IDLE, no pulse; tick with ks=0: cnt+1; on reaching DEBOUNCE_TICKS: go to HELD, cnt=0, key_level=1, key_pulse.
REQ-018 HELD, tick with ks=1: go to DB_RELEASE, cnt=1; tick with ks=0: cnt+1; on reaching LONG_TICKS: long_pulse, cnt=0, next state per REQ-030/031.
REQ-019 REPEAT, tick with ks=1: go to DB_RELEASE, cnt=1; tick with ks=0: cnt+1; on reaching REPEAT_TICKS: key_pulse, cnt=0.
REQ-020 DB_RELEASE, tick with ks=0: go to HELD, cnt=0, key_level stays 1, no pulse; tick with ks=1: cnt+1; on reaching DEBOUNCE_TICKS: go to IDLE, key_level=0, release_pulse.
REQ-021 All outputs SHALL be registered; each pulse is high exactly one clock, in the cycle after the qualifying tick edge.
REQ-022 key_pulse and long_pulse SHALL both assert in the same cycle when the long threshold is hit with auto-repeat enabled.
REQ-023 Counter arithmetic SHALL be unsigned CNT_W bits; the counter SHALL never wrap, because every state resets it at its threshold.
REQ-024 A glitch shorter than DEBOUNCE_TICKS ticks SHALL produce no output change.
REQ-025 key_in transitions between ticks SHALL be visible only through the ks value sampled at the next tick.

Reset
REQ-026 While reset=1: state=IDLE, cnt=0, all outputs 0, synchronizer flops=1 (released).
REQ-027 Reset asserted mid-hold SHALL abort immediately with no release_pulse; after deassertion the block starts in IDLE.
REQ-028 A key held low through reset deassertion SHALL be accepted as a new press after DEBOUNCE_TICKS ticks.

Configuration
REQ-029 Macro KEY_AUTOREPEAT_EN SHALL control auto-repeat.
REQ-030 Defined: at LONG_TICKS, HELD goes to REPEAT and emits key_pulse plus long_pulse.
REQ-031 Undefined: REPEAT state is absent; at LONG_TICKS only long_pulse is emitted, and HELD stays with cnt saturated at LONG_TICKS, giving no further pulses until release.

Verification
REQ-032 Bench ticks every 10 clocks, default parameters: key_in 0 for 3 ticks -> one key_pulse, key_level=1; then 1 for 3 ticks -> one release_pulse, key_level=0.
REQ-033 key_in low for 2 ticks, then high -> no pulses; key_level stays 0.
REQ-034 KEY_AUTOREPEAT_EN defined, key held 163 ticks -> key_pulse at press+0, +100, +120, +140, +160 ticks; long_pulse once at +100.
REQ-035 KEY_AUTOREPEAT_EN undefined, same stimulus -> exactly one key_pulse, one long_pulse, no further pulses.
REQ-036 Held key with a 1-tick high blip at hold tick 50 -> no release_pulse, no new key_pulse; long_pulse at 100 ticks after the blip.
REQ-037 reset pulsed at hold tick 40 -> all outputs 0 in that cycle, no release_pulse; key still low -> new key_pulse 3 ticks after deassertion.
